// File: rtl/ct_spsram_ctrl_pkg.sv
// rtl/ct_spsram_ctrl_pkg.sv - shared state type and geometry constants for the 2048x88 SRAM controller
// Contents: ctrl_state_e {ST_INIT, ST_IDLE}; SRAM depth/width/address width; response FIFO depth.
package ct_spsram_ctrl_pkg;

    localparam int CT_SRAM_DEPTH     = 2048;
    localparam int CT_SRAM_WIDTH     = 88;
    localparam int CT_SRAM_AW        = $clog2(CT_SRAM_DEPTH);
    localparam int CT_RSP_FIFO_DEPTH = 2;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/ct_spsram_ctrl_rsp_fifo.sv
// rtl/ct_spsram_ctrl_rsp_fifo.sv - 2-entry read response FIFO for the SRAM controller
// Ports: clk/rst_n (async active-low); push/push_data in; pop in (ignored when empty);
//        occ = current occupancy; head_vld/head_data = oldest entry.
module ct_spsram_ctrl_rsp_fifo
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = CT_SRAM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [1:0]            occ,
    output logic                  head_vld,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] slot0_q, slot0_d;
    logic [DATA_WIDTH-1:0] slot1_q, slot1_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [1:0]            occ_q, occ_d;
    logic                  pop_ok;

    assign pop_ok    = pop & (occ_q != 2'd0);
    assign occ       = occ_q;
    assign head_vld  = (occ_q != 2'd0);
    assign head_data = rd_ptr_q ? slot1_q : slot0_q;

    // With two slots, push into the slot being popped at full occupancy is safe:
    // the popped value is read from the flop before the edge that overwrites it.
    always_comb begin
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            if (wr_ptr_q) begin
                slot1_d = push_data;
            end else begin
                slot0_d = push_data;
            end
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop_ok})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q  <= '0;
            slot1_q  <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            slot0_q  <= slot0_d;
            slot1_q  <= slot1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

endmodule

// File: rtl/ct_spsram_2048x88_ctrl.sv
// rtl/ct_spsram_2048x88_ctrl.sv - request controller driving a 2048x88 single-port SRAM
// Ports: forever_cpuclk, cpurst_b (async active-low); req_* valid/ready request stream;
//        rsp_* valid/ready read response stream; init_done; mem_* SRAM pins (active-low controls).
// Optional: CT_SPSRAM_CTRL_INIT_EN compiles in the post-reset zero-fill sweep.
module ct_spsram_2048x88_ctrl
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = CT_SRAM_AW,
    parameter int DATA_WIDTH = CT_SRAM_WIDTH
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_cen,
    output logic                  mem_gwen,
    output logic [DATA_WIDTH-1:0] mem_wen,
    output logic [DATA_WIDTH-1:0] mem_d,
    input  logic [DATA_WIDTH-1:0] mem_q
);

`ifdef CT_SPSRAM_CTRL_INIT_EN
    localparam ctrl_state_e RST_STATE = ST_INIT;
    logic [ADDR_WIDTH-1:0] sweep_cnt_q, sweep_cnt_d;
`else
    localparam ctrl_state_e RST_STATE = ST_IDLE;
`endif

    ctrl_state_e           state_q, state_d;
    logic                  rd_pend_q, rd_pend_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [DATA_WIDTH-1:0] mem_d_q, mem_d_d;
    logic [1:0]            occ;
    logic                  pop;
    logic [2:0]            rd_used;
    logic                  rd_credit;

    // Pin-facing outputs are decoded from state combinationally; qualifying with
    // cpurst_b keeps them at their idle values for the whole time reset is held.
    assign init_done = cpurst_b & (state_q == ST_IDLE);
    assign pop       = rsp_vld & rsp_rdy;
    // Reads in use after this cycle's pop: FIFO entries plus the read in flight.
    assign rd_used   = {1'b0, occ} - {2'b0, pop} + {2'b0, rd_pend_q};
    assign rd_credit = (rd_used < 3'd2);

    always_comb begin
        state_d   = state_q;
        rd_pend_d = 1'b0;
        req_rdy   = 1'b0;
        mem_cen   = 1'b1;
        mem_gwen  = 1'b1;
        mem_wen   = '1;
        mem_a     = mem_a_q;
        mem_d     = mem_d_q;
`ifdef CT_SPSRAM_CTRL_INIT_EN
        sweep_cnt_d = sweep_cnt_q;
`endif
        if (cpurst_b) begin
            case (state_q)
                ST_INIT: begin
`ifdef CT_SPSRAM_CTRL_INIT_EN
                    mem_cen     = 1'b0;
                    mem_gwen    = 1'b0;
                    mem_wen     = '0;
                    mem_d       = '0;
                    mem_a       = sweep_cnt_q;
                    sweep_cnt_d = sweep_cnt_q + 1'b1;
                    if (&sweep_cnt_q) begin
                        state_d = ST_IDLE;
                    end
`endif
                end
                ST_IDLE: begin
                    req_rdy = req_wr | rd_credit;
                    if (req_vld && req_rdy) begin
                        mem_cen = 1'b0;
                        mem_a   = req_addr;
                        if (req_wr) begin
                            mem_gwen = 1'b0;
                            mem_wen  = ~req_wmask;
                            mem_d    = req_wdata;
                        end else begin
                            rd_pend_d = 1'b1;
                        end
                    end
                end
                default: state_d = RST_STATE;
            endcase
        end
        mem_a_d = mem_a;
        mem_d_d = mem_d;
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q   <= RST_STATE;
            rd_pend_q <= 1'b0;
            mem_a_q   <= '0;
            mem_d_q   <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= rd_pend_d;
            mem_a_q   <= mem_a_d;
            mem_d_q   <= mem_d_d;
        end
    end

`ifdef CT_SPSRAM_CTRL_INIT_EN
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            sweep_cnt_q <= '0;
        end else begin
            sweep_cnt_q <= sweep_cnt_d;
        end
    end
`endif

    // mem_q is valid in the cycle after a read accept; that is exactly when rd_pend_q is set.
    ct_spsram_ctrl_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk       (forever_cpuclk),
        .rst_n     (cpurst_b),
        .push      (rd_pend_q),
        .push_data (mem_q),
        .pop       (pop),
        .occ       (occ),
        .head_vld  (rsp_vld),
        .head_data (rsp_data)
    );

endmodule
